// File: rtl/i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// i2c_slave_responder
//
// I2C target that answers a single master on one bus. It detects START and
// STOP, matches a 7-bit address, ACKs address and write bytes, stores written
// bytes in a DEPTH-entry buffer and returns buffer bytes on reads. Byte and
// transaction strobes are provided for scoreboarding.
//
// Ports:
//   clk_i        system clock (at least 10x SCL)
//   rst_i        asynchronous active-low reset
//   scl_i/sda_i  asynchronous bus inputs
//   sda_o        open-drain data drive (0 = pull low, 1 = release)
//   mem_we_i     host preload strobe, with mem_addr_i / mem_wdata_i
//   rx_valid_o   one-cycle pulse per accepted write byte, with rx_data_o
//   busy_o       high from address match until the transaction ends
//   op_done_o    one-cycle pulse at transaction end, with op_rw_o/byte_cnt_o
// ---------------------------------------------------------------------------
module i2c_slave_responder #(
    parameter int unsigned               I2C_ADDR_WIDTH = 7,
    parameter int unsigned               I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
    parameter int unsigned               DEPTH          = 32,
    parameter int unsigned               PTR_WIDTH      = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    input  logic                      mem_we_i,
    input  logic [PTR_WIDTH-1:0]      mem_addr_i,
    input  logic [I2C_DATA_WIDTH-1:0] mem_wdata_i,
    output logic                      rx_valid_o,
    output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
    output logic                      busy_o,
    output logic                      op_done_o,
    output logic                      op_rw_o,
    output logic [7:0]                byte_cnt_o
);

    localparam int unsigned DW = I2C_DATA_WIDTH;
    localparam logic [3:0]  LAST_BIT = 4'(DW - 1);
    localparam logic [3:0]  ALL_BITS = 4'(DW);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WR_DATA   = 3'd3;
    localparam logic [2:0] ST_WR_ACK    = 3'd4;
    localparam logic [2:0] ST_RD_DATA   = 3'd5;
    localparam logic [2:0] ST_RD_ACK    = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    // Bit 0 and 1 form the synchronizer, bit 2 is the edge-detect history.
    logic [2:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic [2:0] state_q, state_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic rw_q, rw_d;
    logic busy_q, busy_d;
    logic sda_q, sda_d;
    // In ACK states: ACK already driven. In RD_ACK: master ACKed.
    logic ack_phase_q, ack_phase_d;
    logic rx_valid_q, rx_valid_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic op_done_q, op_done_d;
    logic op_rw_q, op_rw_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    logic scl_now, scl_prev, sda_now, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [DW-1:0] rd_byte;

    assign scl_now   = scl_sync_q[1];
    assign scl_prev  = scl_sync_q[2];
    assign sda_now   = sda_sync_q[1];
    assign sda_prev  = sda_sync_q[2];
    assign scl_rise  = scl_now & ~scl_prev;
    assign scl_fall  = ~scl_now & scl_prev;
    assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
    assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;
    assign rd_byte   = mem_q[ptr_q];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        scl_sync_d  = {scl_sync_q[1:0], scl_i};
        sda_sync_d  = {sda_sync_q[1:0], sda_i};
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        sda_d       = sda_q;
        ack_phase_d = ack_phase_q;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        op_done_d   = 1'b0;
        op_rw_d     = op_rw_q;
        byte_cnt_d  = byte_cnt_q;
        mem_d       = mem_q;

        // Preload first so that an I2C write to the same entry below wins.
        if (mem_we_i) begin
            mem_d[mem_addr_i] = mem_wdata_i;
        end

        if (start_det || stop_det) begin
            // Bus conditions abandon any partial byte and end a matched transaction.
            if (busy_q) begin
                op_done_d  = 1'b1;
                op_rw_d    = rw_q;
                byte_cnt_d = cnt_q;
                busy_d     = 1'b0;
            end
            sda_d       = 1'b1;
            bit_cnt_d   = 4'd0;
            ack_phase_d = 1'b0;
            state_d     = start_det ? ST_ADDR : ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[DW-2:0], sda_now};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            if (shift_d[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
                                state_d     = ST_ADDR_ACK;
                                busy_d      = 1'b1;
                                ptr_d       = '0;
                                cnt_d       = 8'd0;
                                rw_d        = sda_now;
                                ack_phase_d = 1'b0;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    // First fall pulls SDA low, second fall ends the ACK bit.
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_d       = 1'b0;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                sda_d     = rd_byte[DW-1];
                                shift_d   = {rd_byte[DW-2:0], 1'b0};
                                bit_cnt_d = 4'd1;
                                state_d   = ST_RD_DATA;
                            end else begin
                                sda_d     = 1'b1;
                                bit_cnt_d = 4'd0;
                                state_d   = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[DW-2:0], sda_now};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            mem_d[ptr_q] = shift_d;
                            rx_valid_d   = 1'b1;
                            rx_data_d    = shift_d;
                            ptr_d        = ptr_q + PTR_ONE;
                            cnt_d        = sat_inc(cnt_q);
                            ack_phase_d  = 1'b0;
                            state_d      = ST_WR_ACK;
                        end
                    end
                end
                ST_RD_DATA: begin
                    // bit_cnt counts bits already placed on the bus.
                    if (scl_fall) begin
                        if (bit_cnt_q == ALL_BITS) begin
                            sda_d       = 1'b1;
                            ptr_d       = ptr_q + PTR_ONE;
                            cnt_d       = sat_inc(cnt_q);
                            ack_phase_d = 1'b0;
                            state_d     = ST_RD_ACK;
                        end else begin
                            sda_d     = shift_q[DW-1];
                            shift_d   = {shift_q[DW-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_now) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            ack_phase_d = 1'b1;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        sda_d       = rd_byte[DW-1];
                        shift_d     = {rd_byte[DW-2:0], 1'b0};
                        bit_cnt_d   = 4'd1;
                        ack_phase_d = 1'b0;
                        state_d     = ST_RD_DATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Synchronizers reset to the idle-high bus level so no false edge follows reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_sync_q  <= 3'b111;
            sda_sync_q  <= 3'b111;
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= 4'd0;
            ptr_q       <= '0;
            cnt_q       <= 8'd0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            sda_q       <= 1'b1;
            ack_phase_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            op_done_q   <= 1'b0;
            op_rw_q     <= 1'b0;
            byte_cnt_q  <= 8'd0;
            mem_q       <= '{default: '0};
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            sda_q       <= sda_d;
            ack_phase_q <= ack_phase_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            op_done_q   <= op_done_d;
            op_rw_q     <= op_rw_d;
            byte_cnt_q  <= byte_cnt_d;
            mem_q       <= mem_d;
        end
    end

    assign sda_o      = sda_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign busy_o     = busy_q;
    assign op_done_o  = op_done_q;
    assign op_rw_o    = op_rw_q;
    assign byte_cnt_o = byte_cnt_q;

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (slave) that answers the IICMB I2C master on one bus.
- Detects START/STOP, matches a 7-bit address, ACKs, stores written bytes in an internal buffer and returns buffer bytes on reads.
- Gives the bench and fabric a hardware target in place of the behavioural i2c_if, with byte and transaction strobes for scoreboarding.

Parameters:
- I2C_ADDR_WIDTH, 7, target address width (fixed 7-bit addressing)
- I2C_DATA_WIDTH, 8, byte width
- SLAVE_ADDR, 7'h22, address this target responds to (IICMB write of 0x44 = 0x22<<1 | W)
- DEPTH, 32, buffer entries; power of two
- PTR_WIDTH, 5, log2(DEPTH)

Ports:
- clk_i  in  1  system clock; at least 10x SCL frequency
- rst_i  in  1  asynchronous, active-low reset
- scl_i  in  1  I2C clock from bus (asynchronous)
- sda_i  in  1  I2C data from bus (asynchronous)
- sda_o  out  1  open-drain data drive; 0 = pull low, 1 = release
- mem_we_i  in  1  host preload write strobe
- mem_addr_i  in  PTR_WIDTH  host preload address
- mem_wdata_i  in  8  host preload data
- rx_valid_o  out  1  one-cycle pulse per written data byte accepted
- rx_data_o  out  8  byte accompanying rx_valid_o
- busy_o  out  1  high from matched address until transaction end
- op_done_o  out  1  one-cycle pulse at end of an addressed transaction
- op_rw_o  out  1  0 = write, 1 = read; valid with op_done_o
- byte_cnt_o  out  8  data bytes transferred; valid with op_done_o; saturates at 255

Behaviour:
- Reset (rst_i=0, async): sda_o=1, state IDLE, pointer=0, all strobes 0, busy_o=0, rx_data_o=0, op_rw_o=0, byte_cnt_o=0, buffer cleared to 0x00. Reset during a transfer releases SDA immediately; the target then waits for the next START.
- Input conditioning: scl_i and sda_i each pass a 2-flop synchronizer. A third stage provides edge detection. All decisions use synchronized values.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high. Both are recognised in any state and override bit processing.
- Bit timing: sample SDA on a synced SCL rising edge, MSB first. Change sda_o only on a synced SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W). After the 8th rise, go to ADDR_ACK if address == SLAVE_ADDR, otherwise WAIT_STOP.
  - ADDR_ACK: drive sda_o=0 from the next SCL fall to the following fall. Set busy_o=1 and pointer=0. If W, go to WR_DATA. If R, load buffer[pointer] and go to RD_DATA; the MSB is driven on the fall that ends the ACK bit.
  - WR_DATA: shift 8 bits. After the 8th rise, write buffer[pointer], pulse rx_valid_o with rx_data_o (next cycle), increment pointer and byte count. Go to WR_ACK.
  - WR_ACK: drive ACK as in ADDR_ACK, then return to WR_DATA.
  - RD_DATA: present one bit per SCL fall. After the 8th bit's fall, release SDA, increment pointer and byte count, go to RD_ACK.
  - RD_ACK: sample master SDA on the 9th rise. 0 (ACK): load buffer[pointer] and drive its MSB on the next fall, back to RD_DATA. 1 (NACK): go to WAIT_STOP, SDA released.
  - WAIT_STOP: SDA released; ignore bits until STOP or START.
- Transaction end: a STOP, or a repeated START while busy_o=1, pulses op_done_o for one cycle with op_rw_o and byte_cnt_o, then clears busy_o. A repeated START goes to ADDR. Pointer resets only on an address match, so a write then a restarted read returns data from entry 0.
- Pointer wraps modulo DEPTH. Writes beyond DEPTH overwrite from entry 0; this is not an error.
- A STOP or START arriving mid-byte abandons the partial byte: no buffer write, no rx_valid_o.
- A host preload and an I2C write in the same cycle to the same entry: the I2C write wins.
- No clock stretching; SCL is never driven.

Test Plan:
- Write 0x44, then data 0..31, then STOP -> ACK on all 33 bytes; 32 rx_valid_o pulses carrying 0..31; op_done_o with op_rw_o=0 and byte_cnt_o=32; buffer[i]=i.
- Preload buffer[i]=0xA0+i; address 0x45, read 4 bytes with the master NACKing the 4th -> master receives A0, A1, A2, A3; op_done_o with op_rw_o=1 and byte_cnt_o=4; SDA released after the NACK.
- Address 0x46 (non-matching) with 2 data bytes -> sda_o stays 1 throughout; master reads NAK; no strobes; busy_o stays 0.
- Write 0x44 with data 0x11, 0x22, then repeated START, 0x45, read 2 bytes -> op_done_o (W, count 2), then (R, count 2); read data is 0x11, 0x22.
- Write 34 bytes 0..33 -> buffer[0]=32, buffer[1]=33, buffer[2]=2; byte_cnt_o=34.
- rst_i driven low during the 5th bit of a read byte -> sda_o=1 within the same cycle; state IDLE; next transaction from a START is ACKed normally.
